uart_tx: RTL and testbench

- Serial UART transmitter at the far end of the interconnect's UART port.
- Accepts a byte from the fabric (MIPS store or DMA stream) through the uart_data_in / uart_data_av / uart_ready handshake.
- Shifts the byte out as an 8N1 frame on tx: LSB first, one start bit, one stop bit.
- Drives uart_ready, which the fabric uses both for MIPS polling and for DMA write pacing.

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between the interconnect fabric and the UART transmitter.
// The fabric drives data/valid; the transmitter drives ready.
interface uart_tx_if;
    logic [7:0] uart_data_in;
    logic       uart_data_av;
    logic       uart_ready;

    modport master (
        output uart_data_in,
        output uart_data_av,
        input  uart_ready
    );

    modport slave (
        input  uart_data_in,
        input  uart_data_av,
        output uart_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 serial frame, LSB first, registered tx/ready.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } state_t;
`endif

    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(CLKS_PER_BIT - 1);

    state_t               r_state;
    state_t               w_state_n;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_n;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_n;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_n;
    logic                 r_tx;
    logic                 w_tx_n;
    logic                 r_ready;
    logic                 w_ready_n;
    logic                 w_term;
`ifdef UART_TX_PARITY_EN
    logic                 r_par;
    logic                 w_par_n;
`endif

    assign w_term         = (r_cnt == TERM);
    assign tx             = r_tx;
    assign bus.uart_ready = r_ready;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
            r_ready <= w_ready_n;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_n;
`endif
        end
    end

    // Next-state logic; tx/ready are computed one edge ahead so they stay registered.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CNT_WIDTH'(1);
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_ready_n = r_ready;
`ifdef UART_TX_PARITY_EN
        w_par_n   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_n   = '0;
                w_idx_n   = '0;
                w_tx_n    = 1'b1;
                w_ready_n = 1'b1;
                if (bus.uart_data_av) begin
                    w_shift_n = bus.uart_data_in;
                    w_state_n = S_START;
                    w_tx_n    = 1'b0;
                    w_ready_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_par_n   = ^bus.uart_data_in;
`endif
                end
            end
            S_START: begin
                if (w_term) begin
                    w_cnt_n   = '0;
                    w_state_n = S_DATA;
                    w_tx_n    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_term) begin
                    w_cnt_n   = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    w_idx_n   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = S_PARITY;
                        w_tx_n    = r_par;
`else
                        w_state_n = S_STOP;
                        w_tx_n    = 1'b1;
`endif
                    end else begin
                        w_tx_n = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_term) begin
                    w_cnt_n   = '0;
                    w_state_n = S_STOP;
                    w_tx_n    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_term) begin
                    w_cnt_n   = '0;
                    w_state_n = S_IDLE;
                    w_tx_n    = 1'b1;
                    w_ready_n = 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
                w_idx_n   = '0;
                w_tx_n    = 1'b1;
                w_ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int N  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F  = NB * N + 1;
    localparam int C  = 2 * F + 8;

    logic clk;
    logic rst;
    logic tx;
    logic av_man;
    logic dma;
    int   npass;
    int   ntot;
    logic tx_s [0:C-1];
    logic rd_s [0:C-1];

    uart_tx_if bus ();

    assign bus.uart_data_av = dma ? bus.uart_ready : av_man;

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle tx", {31'd0, tx}, 32'd1);
            chk("idle ready", {31'd0, bus.uart_ready}, 32'd1);
        end
    endtask

    // Called at a negedge; accepts on the next posedge and checks every cycle.
    task automatic send(input logic [7:0] d, input int poke);
        int   nb;
        logic e;
        bus.uart_data_in = d;
        av_man = 1'b1;
        @(posedge clk);
        for (int k = 0; k < NB * N; k++) begin
            @(negedge clk);
            if (k == 0) begin
                av_man = 1'b0;
                bus.uart_data_in = ~d;
            end
            nb = k / N;
            if (nb == 0) e = 1'b0;
            else if (nb <= 8) e = d[nb-1];
`ifdef UART_TX_PARITY_EN
            else if (nb == 9) e = ^d;
`endif
            else e = 1'b1;
            chk($sformatf("tx %02h k%0d", d, k), {31'd0, tx}, {31'd0, e});
            chk($sformatf("busy %02h k%0d", d, k),
                {31'd0, bus.uart_ready}, 32'd0);
            if (k == poke) begin
                av_man = 1'b1;
                bus.uart_data_in = 8'hFF;
            end else if (k == poke + 1) begin
                av_man = 1'b0;
            end
        end
        @(negedge clk);
        chk("end ready", {31'd0, bus.uart_ready}, 32'd1);
        chk("end tx", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        int fall;
        npass = 0;
        ntot  = 0;
        rst   = 1'b0;
        dma   = 1'b0;
        av_man = 1'b0;
        bus.uart_data_in = 8'h00;

        // reset idle
        repeat (3) begin
            @(negedge clk);
            chk("rst tx", {31'd0, tx}, 32'd1);
            chk("rst ready", {31'd0, bus.uart_ready}, 32'd1);
        end
        rst = 1'b1;
        idle(20);

        // single byte
        send(8'hA5, -1);
        idle(3);

        // busy ignore: av pulse with 0xFF mid-frame
        send(8'hA5, 10);
        idle(20);

        // back-to-back, av tied to ready
        bus.uart_data_in = 8'h00;
        dma = 1'b1;
        for (int c = 0; c < C; c++) begin
            @(negedge clk);
            tx_s[c] = tx;
            rd_s[c] = bus.uart_ready;
            if (c == 0) bus.uart_data_in = 8'hFF;
        end
        dma = 1'b0;
        fall = -1;
        for (int c = 1; c < C; c++)
            if (fall < 0 && tx_s[c-1] && !tx_s[c]) fall = c;
        chk("b2b first start", {31'd0, tx_s[0]}, 32'd0);
        chk("b2b bit0 of 00", {31'd0, tx_s[N]}, 32'd0);
        chk("b2b stop", {31'd0, tx_s[F-2]}, 32'd1);
        chk("b2b gap ready", {31'd0, rd_s[F-2]}, 32'd0);
        chk("b2b idle tx", {31'd0, tx_s[F-1]}, 32'd1);
        chk("b2b idle ready", {31'd0, rd_s[F-1]}, 32'd1);
        chk("b2b second start", {31'd0, tx_s[F]}, 32'd0);
        chk("b2b period", fall, F);
        chk("b2b bit0 of FF", {31'd0, tx_s[F+N]}, 32'd1);
        chk("b2b bit7 of FF", {31'd0, tx_s[F+8*N]}, 32'd1);

        // reset during the third frame, then recover
        rst = 1'b0;
        #1;
        chk("rst b2b tx", {31'd0, tx}, 32'd1);
        chk("rst b2b ready", {31'd0, bus.uart_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        // reset mid-frame during data bit 3 of 0x3C
        bus.uart_data_in = 8'h3C;
        av_man = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 0) av_man = 1'b0;
        end
        chk("3C bit3", {31'd0, tx}, 32'd1);
        chk("3C busy", {31'd0, bus.uart_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst tx", {31'd0, tx}, 32'd1);
        chk("midrst ready", {31'd0, bus.uart_ready}, 32'd1);
        @(negedge clk);
        chk("midrst hold", {31'd0, bus.uart_ready}, 32'd1);
        rst = 1'b1;
        idle(6);
        send(8'h81, -1);
        idle(3);

`ifdef UART_TX_PARITY_EN
        send(8'h07, -1);
        idle(2);
        send(8'h03, -1);
        idle(2);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
